// File: rtl/feedback_uart_rx.sv
// UART 8N1 receiver for the kitchen feedback link. Every good byte is published on rx_byte, and
// status frames (tag 2'b01) are also latched into feedback_sig.
module feedback_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] feedback_sig,
    output logic       feedback_valid,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic [7:0]      fb_sig_q, fb_sig_d;
    logic            rx_valid_q, rx_valid_d;
    logic            fb_valid_q, fb_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_meta_q, rxs_q;

    // Both synchronizer flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            fb_sig_q    <= '0;
            rx_valid_q  <= 1'b0;
            fb_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            fb_sig_q    <= fb_sig_d;
            rx_valid_q  <= rx_valid_d;
            fb_valid_q  <= fb_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        fb_sig_d    = fb_sig_q;
        rx_valid_d  = 1'b0;
        fb_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (!rxs_q) state_d = StStart;
            end
            StStart: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (clk_cnt_q == HalfMax) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? StIdle : StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (clk_cnt_q == FullMax) begin
                    clk_cnt_d = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (clk_cnt_q == FullMax) begin
                    clk_cnt_d = '0;
                    if (rxs_q) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        if (shift_q[1:0] == 2'b01) begin
                            fb_sig_d   = shift_q;
                            fb_valid_d = 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // A held-low line must return high before another start is accepted.
                clk_cnt_d = '0;
                if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_byte        = rx_byte_q;
    assign rx_valid       = rx_valid_q;
    assign feedback_sig   = fb_sig_q;
    assign feedback_valid = fb_valid_q;
    assign frame_err      = frame_err_q;

endmodule
